seg7_scan_driver: RTL and testbench

//  Time-multiplexed driver for N common-anode 7-segment digits, successor to the single-digit decoder.

---
 rtl/seg7_scan_driver.sv | 152 +++++++++++++++
 tb/tb_seg7_scan_driver.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Time-multiplexed driver for N_DIGITS common-anode 7-segment digits.
//   A load strobe captures a packed nibble word and per-digit decimal points
//   into shadow registers. A prescaler divides clk into slots of DIV cycles.
//   Each slot lights one digit, and the first GUARD cycles of every slot keep
//   all anodes dark to prevent ghosting. Leading zeros can be blanked.
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   value_in   packed nibbles, [3:0] is digit 0 (rightmost)
//   dp_in      decimal point request per digit, active-high
//   load       capture value_in / dp_in into the shadow registers
//   blank_en   enable leading-zero blanking
//   seg_out    segments a..g (index 0 = a), active-low, registered
//   dp_out     decimal point, active-low, registered
//   an_out     anode enables, active-low, at most one low, registered
//   digit_idx  index of the digit currently being scanned
module seg7_scan_driver #(
    parameter int unsigned N_DIGITS   = 4,
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned REFRESH_HZ = 1000,
    parameter int unsigned GUARD      = 2,
    parameter int unsigned HEX_EN     = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [4*N_DIGITS-1:0]         value_in,
    input  logic [N_DIGITS-1:0]           dp_in,
    input  logic                          load,
    input  logic                          blank_en,
    output logic [0:6]                    seg_out,
    output logic                          dp_out,
    output logic [N_DIGITS-1:0]           an_out,
    output logic [$clog2(N_DIGITS)-1:0]   digit_idx
);

    localparam int unsigned DIV   = CLK_HZ / REFRESH_HZ;
    localparam int unsigned PW    = $clog2(DIV);
    localparam int unsigned IDX_W = $clog2(N_DIGITS);
    localparam int unsigned VW    = 4 * N_DIGITS;

    localparam logic [PW-1:0]    PRESC_LAST = PW'(DIV - 1);
    localparam logic [PW-1:0]    GUARD_P    = PW'(GUARD);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DIGITS - 1);

    logic [VW-1:0]       shadow_q, shadow_d;
    logic [N_DIGITS-1:0] dp_sh_q, dp_sh_d;
    logic [PW-1:0]       presc_q, presc_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [0:6]          seg_q, seg_d;
    logic                dpo_q, dpo_d;
    logic [N_DIGITS-1:0] an_q, an_d;

    logic                tick_c;
    logic                guard_c;
    logic                blank_c;
    logic                run_zero;
    logic [N_DIGITS-1:0] zero_sfx;
    logic [3:0]          nib_c;

    // Active-low abcdefg pattern for one nibble
    function automatic logic [0:6] seg_decode(input logic [3:0] nib);
        logic [0:6] s;
        s = 7'b1111111;
        case (nib)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            4'hF: s = 7'b0111000;
        endcase
        if ((HEX_EN == 0) && (nib > 4'd9)) begin
            s = 7'b1111110;
        end
        return s;
    endfunction

    // Next-state: shadow capture, prescaler/digit scan, registered outputs
    always_comb begin
        shadow_d = shadow_q;
        dp_sh_d  = dp_sh_q;
        presc_d  = presc_q;
        idx_d    = idx_q;
        zero_sfx = '0;
        run_zero = 1'b1;

        if (load) begin
            shadow_d = value_in;
            dp_sh_d  = dp_in;
        end

        tick_c = (presc_q == PRESC_LAST);
        if (tick_c) begin
            presc_d = '0;
            idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end else begin
            presc_d = presc_q + PW'(1);
        end

        // zero_sfx[i]: nibbles i..N_DIGITS-1 are all zero
        for (int i = int'(N_DIGITS) - 1; i >= 0; i--) begin
            run_zero    = run_zero && (shadow_q[4*i +: 4] == 4'h0);
            zero_sfx[i] = run_zero;
        end

        guard_c = (presc_q < GUARD_P);
        blank_c = blank_en && (idx_q != '0) && zero_sfx[idx_q];
        nib_c   = shadow_q[4*int'(idx_q) +: 4];

        an_d  = (guard_c || blank_c) ? '1 : ~(N_DIGITS'(1) << idx_q);
        seg_d = blank_c ? 7'b1111111 : seg_decode(nib_c);
        dpo_d = (guard_c || blank_c) ? 1'b1 : ~dp_sh_q[idx_q];
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q <= '0;
            dp_sh_q  <= '0;
            presc_q  <= '0;
            idx_q    <= '0;
            seg_q    <= 7'b1111111;
            dpo_q    <= 1'b1;
            an_q     <= '1;
        end else begin
            shadow_q <= shadow_d;
            dp_sh_q  <= dp_sh_d;
            presc_q  <= presc_d;
            idx_q    <= idx_d;
            seg_q    <= seg_d;
            dpo_q    <= dpo_d;
            an_q     <= an_d;
        end
    end

    assign seg_out   = seg_q;
    assign dp_out    = dpo_q;
    assign an_out    = an_q;
    assign digit_idx = idx_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver
//   Bench for seg7_scan_driver with N_DIGITS=4, DIV=10, GUARD=2. Two copies
//   are driven in parallel, one with HEX_EN=1 and one with HEX_EN=0. Expected
//   outputs come from an arithmetic model of the scan (slot = cycles / DIV).
module tb_seg7_scan_driver;

    localparam int N     = 4;
    localparam int DIV   = 10;
    localparam int GUARD = 2;

    localparam logic [6:0] SEG [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    logic        clk;
    logic        rst;
    logic [15:0] value_in;
    logic [3:0]  dp_in;
    logic        load;
    logic        blank_en;

    logic [0:6]  seg_h, seg_d;
    logic        dp_h, dp_d;
    logic [3:0]  an_h, an_d;
    logic [1:0]  idx_h, idx_d;

    int checks;
    int errors;

    // Model state: edges since reset release and the shadow contents
    int          cyc;
    logic [15:0] m_sh;
    logic [3:0]  m_dp;

    seg7_scan_driver #(
        .N_DIGITS(4), .CLK_HZ(100), .REFRESH_HZ(10), .GUARD(2), .HEX_EN(1)
    ) dut_hex (
        .clk(clk), .rst(rst), .value_in(value_in), .dp_in(dp_in), .load(load),
        .blank_en(blank_en), .seg_out(seg_h), .dp_out(dp_h), .an_out(an_h),
        .digit_idx(idx_h)
    );

    seg7_scan_driver #(
        .N_DIGITS(4), .CLK_HZ(100), .REFRESH_HZ(10), .GUARD(2), .HEX_EN(0)
    ) dut_dec (
        .clk(clk), .rst(rst), .value_in(value_in), .dp_in(dp_in), .load(load),
        .blank_en(blank_en), .seg_out(seg_d), .dp_out(dp_d), .an_out(an_d),
        .digit_idx(idx_d)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // What the outputs should show after an edge whose pre-edge cycle count is c
    function automatic void model(input int c, input logic [15:0] sh, input logic [3:0] dpv,
                                  input logic be, input bit hex,
                                  output logic [6:0] s, output logic d, output logic [3:0] a);
        int  p;
        int  dg;
        int  nib;
        bit  blanked;
        bit  dark;
        p       = c % DIV;
        dg      = (c / DIV) % N;
        nib     = int'((sh >> (4 * dg)) & 16'hF);
        blanked = be && (dg > 0) && ((sh >> (4 * dg)) == 16'h0);
        dark    = (p < GUARD);
        a = (dark || blanked) ? 4'hF : ~(4'b0001 << dg);
        if (blanked)                s = 7'h7F;
        else if (!hex && nib > 9)   s = 7'b1111110;
        else                        s = SEG[nib];
        d = (dark || blanked) ? 1'b1 : ~dpv[dg];
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_seg"}, {1'b0, seg_h}, 8'h7F);
        chk({tag, "_an"},  {4'h0, an_h},  8'h0F);
        chk({tag, "_dp"},  {7'h0, dp_h},  8'h01);
        chk({tag, "_seg_dec"}, {1'b0, seg_d}, 8'h7F);
        chk({tag, "_an_dec"},  {4'h0, an_d},  8'h0F);
    endtask

    // One clock cycle: predict, clock, update model, compare at negedge
    task automatic step();
        logic [6:0] es_h, es_d;
        logic       ed_h, ed_d;
        logic [3:0] ea_h, ea_d;
        model(cyc, m_sh, m_dp, blank_en, 1'b1, es_h, ed_h, ea_h);
        model(cyc, m_sh, m_dp, blank_en, 1'b0, es_d, ed_d, ea_d);
        @(posedge clk);
        if (load) begin
            m_sh = value_in;
            m_dp = dp_in;
        end
        cyc++;
        @(negedge clk);
        chk("seg_hex", {1'b0, seg_h}, {1'b0, es_h});
        chk("an_hex",  {4'h0, an_h},  {4'h0, ea_h});
        chk("dp_hex",  {7'h0, dp_h},  {7'h0, ed_h});
        chk("idx_hex", {6'h0, idx_h}, 8'((cyc / DIV) % N));
        chk("seg_dec", {1'b0, seg_d}, {1'b0, es_d});
        chk("an_dec",  {4'h0, an_d},  {4'h0, ea_d});
        chk("dp_dec",  {7'h0, dp_d},  {7'h0, ed_d});
        chk("an_one_low", {7'h0, ($countones(~an_h) <= 1)}, 8'h01);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] dp);
        value_in = v;
        dp_in    = dp;
        load     = 1'b1;
        step();
        load     = 1'b0;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        value_in = '0;
        dp_in    = '0;
        load     = 1'b0;
        blank_en = 1'b0;
        cyc      = 0;
        m_sh     = '0;
        m_dp     = '0;

        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Scan of 1234, no blanking
        do_load(16'h1234, 4'b0000);
        run(80);

        // Leading-zero blanking on and off
        blank_en = 1'b1;
        do_load(16'h0070, 4'b0000);
        run(80);
        blank_en = 1'b0;
        run(40);

        // All-zero word: only digit 0 lit
        blank_en = 1'b1;
        do_load(16'h0000, 4'b0000);
        run(40);

        // Hex vs decimal mode and decimal point on digit 1
        blank_en = 1'b0;
        do_load(16'hAB9F, 4'b0010);
        run(40);

        // Input changes without load must not reach the display
        value_in = 16'h5678;
        dp_in    = 4'b1111;
        run(40);

        // Load coinciding with a slot tick (presc at its last value)
        while (cyc % DIV != DIV - 1) step();
        do_load(16'h9E0C, 4'b0101);
        run(40);

        // Asynchronous reset in the middle of a lit window
        while (cyc % DIV != 5) step();
        rst = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        cyc  = 0;
        m_sh = '0;
        m_dp = '0;
        repeat (2) @(negedge clk);
        check_reset_outputs("held_reset");
        chk("held_reset_idx", {6'h0, idx_h}, 8'h00);
        rst = 1'b0;
        run(50);

        // Randomized loads, blanking and inputs
        for (int i = 0; i < 1500; i++) begin
            logic [15:0] v;
            v = 16'($urandom);
            case ($urandom_range(0, 3))
                0: v = v & 16'h000F;
                1: v = v & 16'h00FF;
                2: v = v & 16'h0FFF;
                default: ;
            endcase
            value_in = v;
            dp_in    = 4'($urandom);
            load     = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 63) == 0) blank_en = ~blank_en;
            step();
        end
        load = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
